// File: rtl/sram_wrap_pkg.sv
// Shared types and address helpers for the banked single-port SRAM wrapper.
// Address split: the bank index comes from the MSBs (contiguous) or the LSBs (interleaved).
package sram_wrap_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } sram_state_e;

    function automatic int unsigned bank_idx(input int unsigned addr,
                                             input int unsigned aw,
                                             input int unsigned bw,
                                             input bit          interleave);
        int unsigned mask;
        if (bw == 0) return 0;
        mask = (32'd1 << bw) - 32'd1;
        if (interleave) return addr & mask;
        return (addr >> (aw - bw)) & mask;
    endfunction

    function automatic int unsigned cut_addr(input int unsigned addr,
                                             input int unsigned aw,
                                             input int unsigned bw,
                                             input bit          interleave);
        if (interleave) return addr >> bw;
        return addr & ((32'd1 << (aw - bw)) - 32'd1);
    endfunction

endpackage

// File: rtl/sp_ram_banked_wrap_generic_sram_cut.sv
// Behavioural single-port SRAM cut with active-low controls and retention sleep.
// Tech cuts are mapped onto this port list.
module generic_sram_cut #(
    parameter int unsigned WORDS = 2048,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic                 CLK,
    input  logic                 CSN,
    input  logic                 WEN,
    input  logic [WIDTH/8-1:0]   BEN,
    input  logic [AW-1:0]        A,
    input  logic [WIDTH-1:0]     D,
    input  logic                 SLP,
    output logic [WIDTH-1:0]     Q
);

    logic [WIDTH-1:0] mem_q [WORDS];

    // Contents are never reset; Q only changes on a read.
    always_ff @(posedge CLK) begin
        if (!CSN) begin
            if (!WEN) begin
                for (int i = 0; i < WIDTH / 8; i++) begin
                    if (!BEN[i]) mem_q[A][i*8 +: 8] <= D[i*8 +: 8];
                end
            end else begin
                Q <= mem_q[A];
            end
        end
    end

    a_no_access_in_sleep: assert property (@(posedge CLK) !(!CSN && SLP));

endmodule

// File: rtl/sp_ram_banked_wrap.sv
// Banked single-port SRAM wrapper: req/gnt/rvalid slave port, byte enables,
// and idle-driven retention sleep of all cuts.
//
//   state  | meaning
//   ACTIVE | accesses granted combinationally, idle counter running
//   SLEEP  | all cuts in retention, no grants
//   WAKE   | cuts leaving retention, counting down the wake-up latency
module sp_ram_banked_wrap
    import sram_wrap_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 8192,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned N_BANKS     = 4,
    parameter int unsigned INTERLEAVE  = 0,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic                          we_i,
    input  logic [$clog2(NUM_WORDS)-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       be_i,
    output logic                          rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          sleep_o
);

    localparam int unsigned AW      = $clog2(NUM_WORDS);
    localparam int unsigned BW      = $clog2(N_BANKS);
    localparam int unsigned BWS     = (BW > 0) ? BW : 1;
    localparam int unsigned CW      = AW - BW;
    localparam int unsigned CWS     = (CW > 0) ? CW : 1;
    localparam int unsigned CUT_W   = NUM_WORDS / N_BANKS;
    localparam int unsigned NBE     = DATA_WIDTH / 8;
    localparam int unsigned IDLE_TC = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
    localparam int unsigned ICW     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WAKE_TC = WAKE_CYCLES - 1;
    localparam int unsigned WCW     = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    sram_state_e      state_q, state_d;
    logic [ICW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WCW-1:0]   wake_cnt_q, wake_cnt_d;
    logic [BWS-1:0]   bank_q;
    logic             rd_q;
    logic             rvalid_q;

    logic             gnt;
    logic             slp;
    logic [BWS-1:0]   bank_sel;
    logic [CWS-1:0]   cut_a;
    logic [NBE-1:0]   cut_ben;
    logic [N_BANKS-1:0]    cut_csn;
    logic [DATA_WIDTH-1:0] cut_q [N_BANKS];

    assign bank_sel = BWS'(bank_idx(32'(addr_i), AW, BW, INTERLEAVE != 0));
    assign cut_a    = CWS'(cut_addr(32'(addr_i), AW, BW, INTERLEAVE != 0));
    assign cut_ben  = we_i ? ~be_i : '1;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gnt        = 1'b0;
        slp        = 1'b0;
        unique case (state_q)
            ACTIVE: begin
                gnt = req_i;
                // A request on the expiry cycle wins over going to sleep.
                if (req_i) begin
                    idle_cnt_d = '0;
                end else if (IDLE_CYCLES != 0 && idle_cnt_q == ICW'(IDLE_TC)) begin
                    state_d    = SLEEP;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != ICW'(IDLE_TC)) begin
                    idle_cnt_d = idle_cnt_q + ICW'(1);
                end
            end
            SLEEP: begin
                slp = 1'b1;
                if (req_i) begin
                    state_d    = WAKE;
                    wake_cnt_d = WCW'(WAKE_TC);
                end
            end
            WAKE: begin
                if (wake_cnt_q == '0) state_d = ACTIVE;
                else                  wake_cnt_d = wake_cnt_q - WCW'(1);
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            bank_q     <= '0;
            rd_q       <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            rvalid_q   <= gnt;
            if (gnt) begin
                bank_q <= bank_sel;
                rd_q   <= ~we_i;
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_cut
        assign cut_csn[b] = ~(gnt && bank_sel == BWS'(b));

        generic_sram_cut #(
            .WORDS (CUT_W),
            .WIDTH (DATA_WIDTH),
            .AW    (CWS)
        ) u_cut (
            .CLK (clk),
            .CSN (cut_csn[b]),
            .WEN (~we_i),
            .BEN (cut_ben),
            .A   (cut_a),
            .D   (wdata_i),
            .SLP (slp),
            .Q   (cut_q[b])
        );
    end

    always_comb begin
        rdata_o = '0;
        if (rd_q && rvalid_q) rdata_o = cut_q[bank_q];
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign sleep_o  = (state_q == SLEEP);

endmodule

// File: tb/tb_sp_ram_banked_wrap.sv
// Directed bench: contiguous instance with short sleep timeout, plus an
// interleaved instance with sleep disabled, sharing one requester.
module tb_sp_ram_banked_wrap;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req;
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        gnt0, rvalid0, sleep0;
    logic        gnt1, rvalid1, sleep1;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  exp_csn;

    int n_cmp = 0;
    int n_err = 0;

    sp_ram_banked_wrap #(
        .NUM_WORDS(8192), .DATA_WIDTH(32), .N_BANKS(4), .INTERLEAVE(0),
        .IDLE_CYCLES(4), .WAKE_CYCLES(2)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt0), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .sleep_o(sleep0)
    );

    sp_ram_banked_wrap #(
        .NUM_WORDS(8192), .DATA_WIDTH(32), .N_BANKS(4), .INTERLEAVE(1),
        .IDLE_CYCLES(0), .WAKE_CYCLES(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt1), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .sleep_o(sleep1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [12:0] a, input logic [31:0] d, input logic [3:0] b);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
    endtask

    task automatic go_idle();
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        go_idle();
        step();
        step();
        check_eq("rst_rvalid", 32'(rvalid0), 32'd0);
        check_eq("rst_rdata", rdata0, 32'd0);
        check_eq("rst_sleep", 32'(sleep0), 32'd0);
        check_eq("rst_rvalid_il", 32'(rvalid1), 32'd0);
        rst_n = 1'b1;

        // write then read the top word, which lives in bank 3
        drive(1'b1, 13'h1FFF, 32'hDEADBEEF, 4'hF);
        #1;
        check_eq("wr_gnt", 32'(gnt0), 32'd1);
        check_eq("wr_csn_bank3", 32'(u_dut0.cut_csn), 32'h7);
        step();
        drive(1'b0, 13'h1FFF, 32'h0, 4'hF);
        #1;
        check_eq("rd_gnt", 32'(gnt0), 32'd1);
        check_eq("wr_rvalid", 32'(rvalid0), 32'd1);
        check_eq("wr_rdata_zero", rdata0, 32'd0);
        step();

        // byte enables; a be=0 write must not change anything
        drive(1'b1, 13'h0010, 32'hFFFFFFFF, 4'hF);
        check_eq("rd_rvalid", 32'(rvalid0), 32'd1);
        check_eq("rd_data", rdata0, 32'hDEADBEEF);
        step();
        drive(1'b1, 13'h0010, 32'h00000000, 4'b0101);
        step();
        drive(1'b1, 13'h0010, 32'h12345678, 4'b0000);
        check_eq("be0_rvalid", 32'(rvalid0), 32'd1);
        step();
        drive(1'b0, 13'h0010, 32'h0, 4'hF);
        step();
        check_eq("be_rvalid", 32'(rvalid0), 32'd1);
        check_eq("be_data", rdata0, 32'hFF00FF00);

        // word-interleaved instance: round-robin banks, back-to-back responses
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 13'(i), 32'(i), 4'hF);
            #1;
            exp_csn = ~(4'b0001 << (i % 4));
            check_eq("il_wr_gnt", 32'(gnt1), 32'd1);
            check_eq("il_wr_csn", 32'(u_dut1.cut_csn), 32'(exp_csn));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 13'(i), 32'h0, 4'hF);
            #1;
            exp_csn = ~(4'b0001 << (i % 4));
            check_eq("il_rd_csn", 32'(u_dut1.cut_csn), 32'(exp_csn));
            check_eq("il_rvalid", 32'(rvalid1), 32'd1);
            if (i > 0) check_eq("il_rdata", rdata1, 32'(i - 1));
            step();
        end
        go_idle();
        check_eq("il_rvalid_last", 32'(rvalid1), 32'd1);
        check_eq("il_rdata_last", rdata1, 32'd7);

        // four idle cycles put the cuts to sleep
        step();
        step();
        step();
        check_eq("pre_sleep", 32'(sleep0), 32'd0);
        step();
        check_eq("sleep_entry", 32'(sleep0), 32'd1);

        // wake: first grant 1+WAKE_CYCLES cycles after the request
        drive(1'b0, 13'h1FFF, 32'h0, 4'hF);
        #1;
        check_eq("sleep_gnt", 32'(gnt0), 32'd0);
        step();
        check_eq("wake_sleep", 32'(sleep0), 32'd0);
        check_eq("wake_gnt1", 32'(gnt0), 32'd0);
        step();
        check_eq("wake_gnt2", 32'(gnt0), 32'd0);
        step();
        check_eq("wake_gnt_first", 32'(gnt0), 32'd1);
        step();
        go_idle();
        check_eq("wake_rvalid", 32'(rvalid0), 32'd1);
        check_eq("wake_rd_data", rdata0, 32'hDEADBEEF);

        // request lands exactly on the idle-expiry cycle
        step();
        step();
        step();
        drive(1'b1, 13'h0020, 32'hCAFEF00D, 4'hF);
        #1;
        check_eq("race_gnt", 32'(gnt0), 32'd1);
        step();
        check_eq("race_sleep", 32'(sleep0), 32'd0);
        drive(1'b0, 13'h0020, 32'h0, 4'hF);
        #1;
        check_eq("race_rd_gnt", 32'(gnt0), 32'd1);
        step();
        go_idle();
        check_eq("race_rd", rdata0, 32'hCAFEF00D);

        // reset in the middle of WAKE
        step();
        step();
        step();
        step();
        check_eq("sleep2", 32'(sleep0), 32'd1);
        drive(1'b0, 13'h0010, 32'h0, 4'hF);
        step();
        check_eq("rst_pre_gnt", 32'(gnt0), 32'd0);
        go_idle();
        rst_n = 1'b0;
        step();
        check_eq("rstw_sleep", 32'(sleep0), 32'd0);
        check_eq("rstw_rvalid", 32'(rvalid0), 32'd0);
        check_eq("rstw_rdata", rdata0, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 13'h0010, 32'h0, 4'hF);
        #1;
        check_eq("rst_active_gnt", 32'(gnt0), 32'd1);
        step();
        go_idle();
        check_eq("rst_mem_rvalid", 32'(rvalid0), 32'd1);
        check_eq("rst_mem_kept", rdata0, 32'hFF00FF00);
        check_eq("il_nosleep", 32'(sleep1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_ram_banked_wrap.md
# sp_ram_banked_wrap

Parametrised single-port SRAM wrapper: splits a NUM_WORDS × DATA_WIDTH memory into N_BANKS cuts, presents a req/gnt/rvalid slave port with byte enables, and puts idle cuts into retention sleep. It replaces the fixed-geometry per-size cut wrappers in the instruction and data RAM paths. Contents are retained in sleep and are not cleared by reset.

## Interface
- NUM_WORDS, 8192: total words; power of two, multiple of N_BANKS.
- DATA_WIDTH, 32: word width; multiple of 8.
- N_BANKS, 4: number of cuts; power of two, ≥1.
- INTERLEAVE, 0: 0 = bank select from address MSBs (contiguous); 1 = from LSBs (word-interleaved).
- IDLE_CYCLES, 16: idle cycles before sleep; 0 disables sleep.
- WAKE_CYCLES, 2: wake-up latency in cycles; ≥1.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AW = $clog2(NUM_WORDS)  word address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  DATA_WIDTH/8  byte enables, active-high.
- rvalid_o  out  1  response for the access granted in the previous cycle.
- rdata_o  out  DATA_WIDTH  read data; '0 unless rvalid_o for a read.
- sleep_o  out  1  all cuts in retention.

## Operation
- Bank index: addr_i[AW-1 -: BW] (INTERLEAVE=0) or addr_i[BW-1:0] (INTERLEAVE=1), BW = $clog2(N_BANKS); the remaining bits form the in-cut address. N_BANKS=1: BW=0, single cut.
- Only the selected cut gets CSN low on a granted access. Cut WEN = ~we_i. Cut BEN = ~be_i on writes, all-ones on reads.
- A write with be_i = 0: no byte changes; rvalid_o still asserted.
- FSM ACTIVE/SLEEP/WAKE:
  - ACTIVE: gnt_o = req_i, combinational. The idle counter clears on req_i and increments otherwise. When it reaches IDLE_CYCLES-1 with req_i=0 and IDLE_CYCLES≠0, go to SLEEP next cycle.
  - SLEEP: all cuts SLP=1, CSN=1, sleep_o=1, gnt_o=0. req_i=1 moves to WAKE next cycle.
  - WAKE: SLP=0, gnt_o=0. Count WAKE_CYCLES cycles, then go to ACTIVE. req_i is not required to stay high.
- Requester holds req_i/addr/data until gnt_o (OBI-style). No outstanding-transaction limit beyond one per cycle.
- Registered per grant: bank_q, rd_q = ~we_i, rvalid_q. rdata_o = rd_q & rvalid_q ? Q[bank_q] : '0.
- Simultaneous events:
  - req_i in the cycle the idle counter would expire: the request wins, counter clears, FSM stays ACTIVE.
  - Read immediately after a write to the same address returns the new data (cut is write-then-read across cycles, no bypass needed).

## Timing
- Read latency 1: grant at cycle t, rvalid_o and rdata_o at t+1. Back-to-back grants give back-to-back rvalid_o.
- From SLEEP: req_i at t gives WAKE at t+1, first gnt_o at t+1+WAKE_CYCLES.
- Reset values: FSM ACTIVE, idle counter 0, rvalid_o 0, rdata_o 0, sleep_o 0, bank_q 0, rd_q 0. gnt_o follows req_i immediately after reset.
- Reset mid-WAKE or mid-SLEEP goes to ACTIVE next cycle. An rvalid pending at reset is dropped.

## Structure
- Package sram_wrap_pkg: FSM state enum (ACTIVE, SLEEP, WAKE) and function bank_idx(addr, interleave).
- Sub-module generic_sram_cut holds one bank, instantiated N_BANKS times by generate.
  - Behavioural model parametrised by WORDS and WIDTH.
  - Ports CLK, CSN, WEN, BEN (active-low), A, D, SLP, Q.
  - Q holds its value when not read. Any access attempted with SLP=1 is a simulation assertion error.
  - Tech cuts map onto this sub-module.

## Test plan
- Defaults: write 0xDEADBEEF to addr 0x1FFF (bank 3), then read it. Required: gnt_o same cycle each time; rvalid_o with rdata_o=0xDEADBEEF one cycle after the read grant.
- Byte enables: write 0xFFFFFFFF, then write 0x00000000 with be_i=4'b0101, then read. Required: rdata_o=0xFF00FF00. A write with be_i=0 leaves it unchanged.
- INTERLEAVE=1: write addrs 0–7 with their index, then read them back-to-back. Required: cuts accessed round-robin 0,1,2,3; rvalid_o high 8 consecutive cycles with data 0–7.
- Sleep: IDLE_CYCLES=4, no req for 4 cycles gives sleep_o=1. req_i then gives gnt_o after 1+WAKE_CYCLES=3 cycles, and data written before sleep reads back intact.
- Race: req_i exactly on the idle-expiry cycle. Required: granted, sleep_o stays 0.
- Reset: rst_n low during WAKE gives ACTIVE next cycle, rvalid_o=0 and sleep_o=0. Memory contents are preserved across the reset.
